// File: rtl/sobel_thresh_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sobel_thresh_ctrl                                                        |
// | Up/down key threshold register with single/double press detection.     |
// | Optional build macro: THRESH_WRAP_EN (wrap at the bounds, not saturate). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sobel_thresh_ctrl #(
  parameter int unsigned       TH_W         = 8,
  parameter logic [TH_W-1:0]   TH_DEFAULT   = 8'd80,
  parameter logic [TH_W-1:0]   TH_MIN       = 8'd0,
  parameter logic [TH_W-1:0]   TH_MAX       = 8'd255,
  parameter logic [TH_W-1:0]   STEP         = 8'd1,
  parameter logic [TH_W-1:0]   BIG_STEP     = 8'd16,
  parameter logic [31:0]       DCLK_CNT_MAX = 32'd15_000_000
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            key_up_flag,
  input  logic            key_dn_flag,
  output logic [TH_W-1:0] thresh,
  output logic            thresh_vld,
  output logic            at_min,
  output logic            at_max
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_UP = 2'd1;
  localparam logic [1:0] ST_WAIT_DN = 2'd2;

  localparam logic [2:0] OP_NONE      = 3'd0;
  localparam logic [2:0] OP_UP_FINE   = 3'd1;
  localparam logic [2:0] OP_UP_COARSE = 3'd2;
  localparam logic [2:0] OP_DN_FINE   = 3'd3;
  localparam logic [2:0] OP_DN_COARSE = 3'd4;
  localparam logic [2:0] OP_RESTORE   = 3'd5;

  logic [1:0]      state_q, state_d;
  logic [31:0]     win_cnt_q, win_cnt_d;
  logic [TH_W-1:0] thresh_q, thresh_d;
  logic            thresh_vld_q, thresh_vld_d;
  logic            at_min_q, at_min_d;
  logic            at_max_q, at_max_d;
  logic [2:0]      op;

  logic both_flags;
  logic win_last;

  assign both_flags = key_up_flag & key_dn_flag;
  assign win_last   = (win_cnt_q == (DCLK_CNT_MAX - 32'd1));

  function automatic logic [TH_W-1:0] step_up(input logic [TH_W-1:0] cur,
                                              input logic [TH_W-1:0] amt);
    logic [TH_W:0]   sum;
    logic [TH_W-1:0] res;
    sum = {1'b0, cur} + {1'b0, amt};
    if (sum > {1'b0, TH_MAX}) res = TH_MAX;
    else                      res = sum[TH_W-1:0];
`ifdef THRESH_WRAP_EN
    // Only a step that starts on the bound wraps; overshoot from below clamps.
    if (cur == TH_MAX) res = TH_MIN;
`endif
    return res;
  endfunction

  function automatic logic [TH_W-1:0] step_dn(input logic [TH_W-1:0] cur,
                                              input logic [TH_W-1:0] amt);
    logic [TH_W:0]   floor_v;
    logic [TH_W-1:0] res;
    floor_v = {1'b0, TH_MIN} + {1'b0, amt};
    if ({1'b0, cur} < floor_v) res = TH_MIN;
    else                       res = cur - amt;
`ifdef THRESH_WRAP_EN
    if (cur == TH_MIN) res = TH_MAX;
`endif
    return res;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      win_cnt_q    <= 32'd0;
      thresh_q     <= TH_DEFAULT;
      thresh_vld_q <= 1'b0;
      at_min_q     <= (TH_DEFAULT == TH_MIN);
      at_max_q     <= (TH_DEFAULT == TH_MAX);
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      thresh_q     <= thresh_d;
      thresh_vld_q <= thresh_vld_d;
      at_min_q     <= at_min_d;
      at_max_q     <= at_max_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    if (both_flags) begin
      state_d   = ST_IDLE;
      win_cnt_d = 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          win_cnt_d = 32'd0;
          if (key_up_flag)      state_d = ST_WAIT_UP;
          else if (key_dn_flag) state_d = ST_WAIT_DN;
        end
        ST_WAIT_UP: begin
          if (key_up_flag) begin
            state_d   = ST_IDLE;
            win_cnt_d = 32'd0;
          end else if (key_dn_flag) begin
            // The opposite key resolves the pending press and opens its own window.
            state_d   = ST_WAIT_DN;
            win_cnt_d = 32'd0;
          end else if (win_last) begin
            state_d   = ST_IDLE;
            win_cnt_d = 32'd0;
          end else begin
            win_cnt_d = win_cnt_q + 32'd1;
          end
        end
        ST_WAIT_DN: begin
          if (key_dn_flag) begin
            state_d   = ST_IDLE;
            win_cnt_d = 32'd0;
          end else if (key_up_flag) begin
            state_d   = ST_WAIT_UP;
            win_cnt_d = 32'd0;
          end else if (win_last) begin
            state_d   = ST_IDLE;
            win_cnt_d = 32'd0;
          end else begin
            win_cnt_d = win_cnt_q + 32'd1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          win_cnt_d = 32'd0;
        end
      endcase
    end
  end

  always_comb begin
    op = OP_NONE;
    if (both_flags) begin
      op = OP_RESTORE;
    end else begin
      case (state_q)
        ST_WAIT_UP: begin
          if (key_up_flag)                   op = OP_UP_COARSE;
          else if (key_dn_flag || win_last)  op = OP_UP_FINE;
        end
        ST_WAIT_DN: begin
          if (key_dn_flag)                   op = OP_DN_COARSE;
          else if (key_up_flag || win_last)  op = OP_DN_FINE;
        end
        default: op = OP_NONE;
      endcase
    end

    thresh_d = thresh_q;
    case (op)
      OP_UP_FINE:   thresh_d = step_up(thresh_q, STEP);
      OP_UP_COARSE: thresh_d = step_up(thresh_q, BIG_STEP);
      OP_DN_FINE:   thresh_d = step_dn(thresh_q, STEP);
      OP_DN_COARSE: thresh_d = step_dn(thresh_q, BIG_STEP);
      OP_RESTORE:   thresh_d = TH_DEFAULT;
      default:      thresh_d = thresh_q;
    endcase

    thresh_vld_d = (thresh_d != thresh_q);
    at_min_d     = (thresh_d == TH_MIN);
    at_max_d     = (thresh_d == TH_MAX);
  end

  assign thresh     = thresh_q;
  assign thresh_vld = thresh_vld_q;
  assign at_min     = at_min_q;
  assign at_max     = at_max_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_thresh_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sobel_thresh_ctrl                                                     |
// | Self-checking bench: directed scenarios plus randomized key pulses.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sobel_thresh_ctrl;

  localparam int DCLK   = 10;
  localparam int TH_DEF = 80;
  localparam int FINE   = 1;
  localparam int COARSE = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_up_flag = 1'b0;
  logic       key_dn_flag = 1'b0;
  logic [7:0] thresh;
  logic       thresh_vld;
  logic       at_min;
  logic       at_max;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: value, last-change flag, and the pending press (+1 up, -1 down, 0 none)
  // with its age in cycles since the pulse.
  int m_th  = TH_DEF;
  bit m_vld = 1'b0;
  int pend  = 0;
  int age   = 0;

  always #5 sys_clk = ~sys_clk;

  sobel_thresh_ctrl #(
    .TH_W(8), .TH_DEFAULT(8'd80), .TH_MIN(8'd0), .TH_MAX(8'd255),
    .STEP(8'd1), .BIG_STEP(8'd16), .DCLK_CNT_MAX(32'd10)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .key_up_flag(key_up_flag), .key_dn_flag(key_dn_flag),
    .thresh(thresh), .thresh_vld(thresh_vld), .at_min(at_min), .at_max(at_max)
  );

  function automatic int mdl_up(int t, int s);
`ifdef THRESH_WRAP_EN
    if (t == 255) return 0;
`endif
    return (t + s > 255) ? 255 : t + s;
  endfunction

  function automatic int mdl_dn(int t, int s);
`ifdef THRESH_WRAP_EN
    if (t == 0) return 255;
`endif
    return (t < s) ? 0 : t - s;
  endfunction

  function automatic int mdl_move(int t, int dir, int s);
    return (dir > 0) ? mdl_up(t, s) : mdl_dn(t, s);
  endfunction

  // One clock cycle of stimulus; the model predicts what is visible after the edge.
  task automatic drive(input bit up, input bit dn);
    int nxt;
    nxt = m_th;
    key_up_flag = up;
    key_dn_flag = dn;
    if (up && dn) begin
      nxt  = TH_DEF;
      pend = 0;
    end else if (pend == 0) begin
      if (up || dn) begin
        pend = up ? 1 : -1;
        age  = 0;
      end
    end else begin
      age++;
      if ((pend > 0 && up) || (pend < 0 && dn)) begin
        nxt  = mdl_move(m_th, pend, COARSE);
        pend = 0;
      end else if (up || dn) begin
        nxt  = mdl_move(m_th, pend, FINE);
        pend = up ? 1 : -1;
        age  = 0;
      end else if (age == DCLK) begin
        nxt  = mdl_move(m_th, pend, FINE);
        pend = 0;
      end
    end
    m_vld = (nxt != m_th);
    m_th  = nxt;
    @(posedge sys_clk);
    #1;
    key_up_flag = 1'b0;
    key_dn_flag = 1'b0;
  endtask

  task automatic press(input bit up, input bit dbl);
    drive(up, !up);
    if (dbl) begin
      drive(0, 0);
      drive(up, !up);
    end else begin
      for (int i = 0; i < DCLK; i++) drive(0, 0);
    end
  endtask

  task automatic hold_reset();
    sys_rst = 1'b1;
    m_th = TH_DEF; m_vld = 1'b0; pend = 0; age = 0;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    hold_reset();
    tests_run++;
    if (thresh !== 8'd80 || thresh_vld !== 1'b0 || at_min !== 1'b0 || at_max !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: thresh=%0d vld=%b min=%b max=%b, expected 80 0 0 0",
               thresh, thresh_vld, at_min, at_max);
    end
  endtask

  task automatic test_single_up();
    int t0;
    t0 = m_th;
    drive(1, 0);
    for (int i = 1; i <= DCLK; i++) begin
      drive(0, 0);
      if (i < DCLK) begin
        tests_run++;
        if (thresh !== 8'(t0) || thresh_vld !== 1'b0) begin
          tests_failed++;
          $display("FAIL single_up_early (t+%0d): thresh=%0d vld=%b, expected %0d 0",
                   i + 1, thresh, thresh_vld, t0);
        end
      end
    end
    tests_run++;
    if (thresh !== 8'(t0 + 1) || thresh_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_up_land: thresh=%0d vld=%b, expected %0d 1", thresh, thresh_vld, t0 + 1);
    end
    drive(0, 0);
    tests_run++;
    if (thresh !== 8'(t0 + 1) || thresh_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_up_after: thresh=%0d vld=%b, expected %0d 0", thresh, thresh_vld, t0 + 1);
    end
  endtask

  task automatic test_double_up();
    int t0;
    t0 = m_th;
    drive(1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0);
    drive(1, 0);
    tests_run++;
    if (thresh !== 8'(t0 + 16) || thresh_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL double_up: thresh=%0d vld=%b, expected %0d 1", thresh, thresh_vld, t0 + 16);
    end
    for (int i = 0; i < DCLK + 2; i++) begin
      drive(0, 0);
      tests_run++;
      if (thresh !== 8'(t0 + 16) || thresh_vld !== 1'b0) begin
        tests_failed++;
        $display("FAIL double_up_no_late_step: thresh=%0d vld=%b, expected %0d 0",
                 thresh, thresh_vld, t0 + 16);
      end
    end
  endtask

  task automatic test_up_then_dn();
    int t0;
    t0 = m_th;
    drive(1, 0);
    drive(0, 0);
    drive(0, 0);
    drive(0, 1);
    tests_run++;
    if (thresh !== 8'(t0 + 1) || thresh_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL up_then_dn_up: thresh=%0d vld=%b, expected %0d 1", thresh, thresh_vld, t0 + 1);
    end
    for (int i = 0; i < DCLK; i++) drive(0, 0);
    tests_run++;
    if (thresh !== 8'(t0) || thresh_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL up_then_dn_dn: thresh=%0d vld=%b, expected %0d 1", thresh, thresh_vld, t0);
    end
  endtask

  task automatic test_saturate();
    while (m_th + 16 <= 250) press(1, 1);
    while (m_th < 250) press(1, 0);
    tests_run++;
    if (thresh !== 8'd250) begin
      tests_failed++;
      $display("FAIL sat_ramp: thresh=%0d, expected 250", thresh);
    end
    press(1, 1);
    tests_run++;
    if (thresh !== 8'd255 || at_max !== 1'b1 || at_min !== 1'b0 || thresh_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_reach_max: thresh=%0d max=%b min=%b vld=%b, expected 255 1 0 1",
               thresh, at_max, at_min, thresh_vld);
    end
    press(1, 1);
`ifdef THRESH_WRAP_EN
    tests_run++;
    if (thresh !== 8'd0 || at_min !== 1'b1 || at_max !== 1'b0 || thresh_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_past_max: thresh=%0d min=%b max=%b vld=%b, expected 0 1 0 1",
               thresh, at_min, at_max, thresh_vld);
    end
`else
    tests_run++;
    if (thresh !== 8'd255 || at_max !== 1'b1 || thresh_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_hold_max: thresh=%0d max=%b vld=%b, expected 255 1 0",
               thresh, at_max, thresh_vld);
    end
`endif
  endtask

  task automatic test_restore();
    drive(1, 1);
    while (m_th - 16 >= 40) press(0, 1);
    while (m_th > 40) press(0, 0);
    tests_run++;
    if (thresh !== 8'd40) begin
      tests_failed++;
      $display("FAIL restore_ramp: thresh=%0d, expected 40", thresh);
    end
    drive(1, 0);
    drive(1, 1);
    tests_run++;
    if (thresh !== 8'd80 || thresh_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL restore_from_40: thresh=%0d vld=%b, expected 80 1", thresh, thresh_vld);
    end
    for (int i = 0; i < DCLK + 2; i++) begin
      drive(0, 0);
      tests_run++;
      if (thresh !== 8'd80 || thresh_vld !== 1'b0) begin
        tests_failed++;
        $display("FAIL restore_dropped_press: thresh=%0d vld=%b, expected 80 0", thresh, thresh_vld);
      end
    end
    drive(1, 1);
    tests_run++;
    if (thresh !== 8'd80 || thresh_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL restore_at_default: thresh=%0d vld=%b, expected 80 0", thresh, thresh_vld);
    end
  endtask

  task automatic test_reset_mid_window();
    drive(1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0);
    hold_reset();
    for (int i = 0; i < DCLK + 3; i++) begin
      drive(0, 0);
      tests_run++;
      if (thresh !== 8'd80 || thresh_vld !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_window: thresh=%0d vld=%b, expected 80 0", thresh, thresh_vld);
      end
    end
  endtask

  task automatic test_random();
    bit up, dn;
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 1500; i++) begin
        up = ($urandom_range(0, 7) < ((phase == 1) ? 2 : 1));
        dn = ($urandom_range(0, 7) < ((phase == 2) ? 2 : 1));
        drive(up, dn);
        tests_run++;
        if (thresh !== 8'(m_th) || thresh_vld !== m_vld ||
            at_min !== (m_th == 0) || at_max !== (m_th == 255)) begin
          tests_failed++;
          $display("FAIL random (phase %0d cyc %0d): thresh=%0d vld=%b min=%b max=%b, expected %0d %b %b %b",
                   phase, i, thresh, thresh_vld, at_min, at_max,
                   m_th, m_vld, (m_th == 0), (m_th == 255));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_double_up();
    test_up_then_dn();
    test_saturate();
    test_restore();
    test_reset_mid_window();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
